// File: rtl/da_fir_filter_param_if.sv
// Sample, coefficient-load and result signals of the DA FIR filter.
// The filter sits on the slave side; the sample/coefficient source drives the master side.
interface da_fir_filter_param_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LUT_W   = 20,
  parameter int unsigned CADDR_W = 11,
  parameter int unsigned OUT_W   = 16
);
  logic signed [DATA_W-1:0]  din;
  logic                      valid_in;
  logic                      in_ready;
  logic signed [LUT_W-1:0]   cin;
  logic        [CADDR_W-1:0] caddr;
  logic                      cload;
  logic                      clear;
  logic signed [OUT_W-1:0]   dout;
  logic                      valid_out;
  logic                      sat;
  logic                      coef_err;

  modport master (
    output din, valid_in, cin, caddr, cload, clear,
    input  in_ready, dout, valid_out, sat, coef_err
  );

  modport slave (
    input  din, valid_in, cin, caddr, cload, clear,
    output in_ready, dout, valid_out, sat, coef_err
  );
endinterface

// File: rtl/da_fir_filter_param.sv
// Distributed-arithmetic FIR: grouped partial-sum LUTs evaluated bit-serially (LSB first),
// followed by rounding, arithmetic right shift and saturation of the accumulator.
module da_fir_filter_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAPS      = 64,
  parameter int unsigned GROUP     = 8,
  parameter int unsigned LUT_W     = 20,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                 clk_fast_i,
  input  logic                 resetn_i,
  da_fir_filter_param_if.slave bus_io
);
  localparam int unsigned NGRP    = TAPS / GROUP;
  localparam int unsigned BANK_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned CADDR_W = $clog2(NGRP) + GROUP;
  localparam int unsigned ACC_W   = LUT_W + DATA_W + $clog2(NGRP) + 1;
  localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam int unsigned ENTRIES = 2 ** GROUP;

  localparam logic signed [ACC_W-1:0] RND     = (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_POS) : '0;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [BIT_W-1:0]   bit_q, bit_d;
  logic signed [OUT_W-1:0]   dout_q, dout_d;
  logic                      valid_out_q, valid_out_d;
  logic                      sat_q, sat_d;
  logic                      coef_err_q, coef_err_d;

  // Partial-sum tables are plain storage: software reloads them, reset leaves them alone.
  logic signed [LUT_W-1:0]   lut_q [NGRP][ENTRIES];
  logic                      lut_we;
  logic        [CADDR_W-1:0] bank_raw;
  logic                      bank_ok;
  logic        [BANK_W-1:0]  bank_idx;
  logic        [GROUP-1:0]   entry_idx;

  assign bank_raw  = bus_io.caddr >> GROUP;
  assign bank_ok   = bank_raw < CADDR_W'(NGRP);
  assign bank_idx  = bank_raw[BANK_W-1:0];
  assign entry_idx = bus_io.caddr[GROUP-1:0];

  always_ff @(posedge clk_fast_i) begin
    if (lut_we) begin
      lut_q[bank_idx][entry_idx] <= bus_io.cin;
    end
  end

  // Current bit-slice of each tap group forms that group's LUT address.
  logic [GROUP-1:0] grp_addr [NGRP];

  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_addr[g] = '0;
      for (int j = 0; j < GROUP; j++) begin
        grp_addr[g][j] = x_q[g*GROUP+j][bit_q];
      end
    end
  end

  logic signed [ACC_W-1:0] lut_sum;
  logic signed [ACC_W-1:0] lut_term;
  logic        [LUT_W-1:0] lut_word;

  always_comb begin
    lut_sum  = '0;
    lut_word = '0;
    for (int g = 0; g < NGRP; g++) begin
      lut_word = lut_q[g][grp_addr[g]];
      lut_sum  = lut_sum + {{(ACC_W-LUT_W){lut_word[LUT_W-1]}}, lut_word};
    end
  end

  assign lut_term = lut_sum <<< bit_q;

  logic signed [ACC_W-1:0] acc_rnd;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [OUT_W-1:0] q_sat;
  logic                    q_clip;

  always_comb begin
    acc_rnd = acc_q + RND;
    acc_shr = acc_rnd >>> OUT_SHIFT;
    q_sat   = acc_shr[OUT_W-1:0];
    q_clip  = 1'b0;
    if (acc_shr > OUT_MAX) begin
      q_sat  = OUT_MAX[OUT_W-1:0];
      q_clip = 1'b1;
    end else if (acc_shr < OUT_MIN) begin
      q_sat  = OUT_MIN[OUT_W-1:0];
      q_clip = 1'b1;
    end
  end

  logic last_bit;
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    bit_d       = bit_q;
    dout_d      = dout_q;
    valid_out_d = 1'b0;
    sat_d       = sat_q;
    coef_err_d  = coef_err_q;
    lut_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Coefficient load beats clear, and clear beats an incoming sample.
        if (bus_io.cload) begin
          lut_we = bank_ok;
        end else if (bus_io.clear) begin
          for (int i = 0; i < TAPS; i++) begin
            x_d[i] = '0;
          end
        end else if (bus_io.valid_in) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = bus_io.din;
          acc_d   = '0;
          bit_d   = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        if (bus_io.cload) begin
          coef_err_d = 1'b1;
        end
        // MSB carries negative weight in two's complement.
        if (last_bit) begin
          acc_d   = acc_q - lut_term;
          state_d = StDone;
        end else begin
          acc_d = acc_q + lut_term;
          bit_d = bit_q + 1'b1;
        end
      end
      StDone: begin
        if (bus_io.cload) begin
          coef_err_d = 1'b1;
        end
        dout_d      = q_sat;
        sat_d       = q_clip;
        valid_out_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_fast_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      x_q         <= '{default: '0};
      acc_q       <= '0;
      bit_q       <= '0;
      dout_q      <= '0;
      valid_out_q <= 1'b0;
      sat_q       <= 1'b0;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      bit_q       <= bit_d;
      dout_q      <= dout_d;
      valid_out_q <= valid_out_d;
      sat_q       <= sat_d;
      coef_err_q  <= coef_err_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle) && !bus_io.cload;
  assign bus_io.dout      = dout_q;
  assign bus_io.valid_out = valid_out_q;
  assign bus_io.sat       = sat_q;
  assign bus_io.coef_err  = coef_err_q;

endmodule
